// File: rtl/clock_div_bank.sv
// Bank of independent runtime-programmable clock dividers.
// Each channel toggles div_clk every D cycles and emits a one-cycle tick on each rising edge.
module clock_div_bank #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned DEFAULT_DIV = 50000,
  parameter int unsigned SEL_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] en,
  input  logic                cfg_we,
  input  logic [SEL_W-1:0]    cfg_sel,
  input  logic [CNT_W-1:0]    cfg_div,
  output logic [CHANNELS-1:0] div_clk,
  output logic [CHANNELS-1:0] tick
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] act_div;
    logic [CNT_W-1:0] shd_div;
    logic [CNT_W-1:0] eff_div;
    logic             pend;
    logic             clk_q;
    logic             tick_q;
    logic             boundary;
    logic             wr_hit;

    always_comb begin
      eff_div  = (act_div == '0) ? CNT_W'(1) : act_div;
      boundary = (cnt == eff_div - CNT_W'(1));
      // Out-of-range selects never match any channel index, so they are dropped.
      wr_hit   = cfg_we && (cfg_sel == SEL_W'(i));
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt     <= '0;
        clk_q   <= 1'b0;
        tick_q  <= 1'b0;
        act_div <= CNT_W'(DEFAULT_DIV);
        shd_div <= CNT_W'(DEFAULT_DIV);
        pend    <= 1'b0;
      end else begin
        if (!en[i]) begin
          cnt    <= '0;
          clk_q  <= 1'b0;
          tick_q <= 1'b0;
          if (pend) act_div <= shd_div;
        end else if (boundary) begin
          cnt    <= '0;
          clk_q  <= ~clk_q;
          tick_q <= ~clk_q;
          if (pend) act_div <= shd_div;
        end else begin
          cnt    <= cnt + CNT_W'(1);
          tick_q <= 1'b0;
        end
        // A write landing on the consuming edge re-arms pend with the new value.
        if (wr_hit) begin
          shd_div <= cfg_div;
          pend    <= 1'b1;
        end else if (pend && (!en[i] || boundary)) begin
          pend <= 1'b0;
        end
      end
    end

    assign div_clk[i] = clk_q;
    assign tick[i]    = tick_q;
  end

endmodule

// File: tb/tb_clock_div_bank.sv
// Self-checking bench for clock_div_bank: countdown reference model feeding a scoreboard queue.
module tb_clock_div_bank;
  localparam int CH = 3;
  localparam int CW = 32;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CH-1:0] en = '0;
  logic          cfg_we = 1'b0;
  logic [SW-1:0] cfg_sel = '0;
  logic [CW-1:0] cfg_div = '0;
  logic [CH-1:0] div_clk;
  logic [CH-1:0] tick;

  clock_div_bank #(
    .CHANNELS(CH),
    .CNT_W(CW),
    .DEFAULT_DIV(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .en(en),
    .cfg_we(cfg_we),
    .cfg_sel(cfg_sel),
    .cfg_div(cfg_div),
    .div_clk(div_clk),
    .tick(tick)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [2*CH-1:0] sb[$];

  int unsigned m_act[CH];
  int unsigned m_shd[CH];
  bit          m_pend[CH];
  bit          m_clk[CH];
  bit          m_tick[CH];
  int          m_rem[CH];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned eff(input int unsigned d);
    return (d == 0) ? 1 : d;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_act[i] = 4; m_shd[i] = 4; m_pend[i] = 0;
      m_clk[i] = 0; m_tick[i] = 0; m_rem[i] = 4;
    end
  endtask

  // Countdown of edges remaining in the current half-period.
  task automatic model_step(input bit we, input int sel, input int unsigned dv);
    for (int i = 0; i < CH; i++) begin
      if (!en[i]) begin
        if (m_pend[i]) begin m_act[i] = m_shd[i]; m_pend[i] = 0; end
        m_clk[i] = 0; m_tick[i] = 0; m_rem[i] = int'(eff(m_act[i]));
      end else begin
        m_rem[i]--;
        if (m_rem[i] == 0) begin
          m_tick[i] = !m_clk[i];
          m_clk[i]  = !m_clk[i];
          if (m_pend[i]) begin m_act[i] = m_shd[i]; m_pend[i] = 0; end
          m_rem[i] = int'(eff(m_act[i]));
        end else begin
          m_tick[i] = 0;
        end
      end
    end
    if (we && sel < CH) begin m_shd[sel] = dv; m_pend[sel] = 1; end
  endtask

  function automatic logic [2*CH-1:0] model_out();
    logic [2*CH-1:0] o;
    for (int i = 0; i < CH; i++) begin
      o[i]      = m_clk[i];
      o[CH + i] = m_tick[i];
    end
    return o;
  endfunction

  task automatic cycle(input bit we = 0, input int sel = 0, input int unsigned dv = 0);
    logic [2*CH-1:0] exp;
    logic [SW-1:0]   s;
    s       = sel[SW-1:0];
    cfg_we  = we;
    cfg_sel = s;
    cfg_div = dv;
    if (!rst_n) model_reset();
    else model_step(we, sel, dv);
    sb.push_back(model_out());
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    if (sb.size() == 0) begin
      check_val("sb_empty", 32'd1, 32'd0);
    end else begin
      exp = sb.pop_front();
      check_val("div_clk", 32'(div_clk), 32'(exp[CH-1:0]));
      check_val("tick", 32'(tick), 32'(exp[2*CH-1:CH]));
    end
  endtask

  initial begin
    int tc;
    model_reset();
    en = '1;
    repeat (3) cycle();

    rst_n = 1'b1;
    repeat (4) cycle();
    check_val("first_rise", 32'(div_clk), 32'h7);
    check_val("first_tick", 32'(tick), 32'h7);
    tc = 0;
    for (int k = 0; k < 16; k++) begin cycle(); tc += int'(tick[0]); end
    check_val("tick_cnt_d4", 32'(tc), 32'd2);

    en[1] = 1'b0;
    cycle(1, 1, 3);
    cycle();
    en[1] = 1'b1;
    tc = 0;
    for (int k = 0; k < 24; k++) begin cycle(); tc += int'(tick[1]); end
    check_val("tick_cnt_d3", 32'(tc), 32'd4);

    cycle(1, 2, 0);
    repeat (10) cycle();
    cycle(1, 2, 1);
    repeat (10) cycle();

    en[0] = 1'b0;
    cycle();
    en[0] = 1'b1;
    cycle();
    cycle(1, 0, 2);
    repeat (16) cycle();
    for (int k = 0; k < 10 && m_rem[0] != 1; k++) cycle();
    cycle(1, 0, 5);
    repeat (20) cycle();

    for (int k = 0; k < 12 && !m_clk[0]; k++) cycle();
    en[0] = 1'b0;
    cycle();
    check_val("en_drop", 32'(div_clk[0]), 32'd0);
    repeat (3) cycle();
    en[0] = 1'b1;
    repeat (5) cycle();

    cycle(1, 1, 7);
    #2 rst_n = 1'b0;
    #1 check_val("async_rst", 32'({tick, div_clk}), 32'd0);
    model_reset();
    #1 rst_n = 1'b1;
    repeat (24) cycle();

    cycle(1, 3, 7);
    repeat (24) cycle();

    repeat (300) begin
      en = CH'($urandom);
      if ($urandom_range(0, 3) == 0)
        cycle(1, int'($urandom_range(0, 3)), $urandom_range(0, 5));
      else
        cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
